// File: rtl/gpio_defaults_pkg.sv
// Shared types and constants for the GPIO default configuration bank.
package gpio_defaults_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD
    } ser_state_e;

    localparam logic [9:0] GPIO_DEFAULT_WORD = 10'h007;

    // Index width for a range of n entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_defaults_serializer.sv
// Shifts the packed configuration words into the GPIO control chain,
// MSB of the packed vector first, then pulses serial_load.
module gpio_defaults_serializer
    import gpio_defaults_pkg::*;
#(
    parameter int unsigned TOTAL_BITS = 380,
    parameter int unsigned CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [TOTAL_BITS-1:0] words,
    output logic                  busy,
    output logic                  serial_clock,
    output logic                  serial_load,
    output logic                  serial_data_out
);

    localparam int unsigned BIT_W = idx_width(TOTAL_BITS);
    localparam int unsigned DIV_W = idx_width(CLK_DIV);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(TOTAL_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    ser_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             sdo_q, sdo_d;
    logic             phase_done;
    logic [BIT_W-1:0] bit_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sdo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sdo_q   <= sdo_d;
        end
    end

    // bit_q indexes the packed vector directly, so the down-count from the
    // top bit yields channel NUM_GPIO-1 MSB first down to channel 0 LSB.
    always_comb begin
        phase_done = (div_q == DIV_LAST);
        bit_next   = bit_q - BIT_W'(1);
        state_d    = state_q;
        div_d      = phase_done ? '0 : div_q + DIV_W'(1);
        bit_d      = bit_q;
        sdo_d      = sdo_q;
        unique case (state_q)
            IDLE: begin
                div_d = '0;
                if (start) begin
                    state_d = SHIFT_LO;
                    bit_d   = LAST_BIT;
                    sdo_d   = words[LAST_BIT];
                end
            end
            SHIFT_LO: begin
                if (phase_done) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_done) begin
                    if (bit_q != '0) begin
                        state_d = SHIFT_LO;
                        bit_d   = bit_next;
                        sdo_d   = words[bit_next];
                    end else begin
                        state_d = LOAD;
                        sdo_d   = 1'b0;
                    end
                end
            end
            LOAD: begin
                if (phase_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                sdo_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy            = (state_q != IDLE);
        serial_clock    = (state_q == SHIFT_HI);
        serial_load     = (state_q == LOAD);
        serial_data_out = sdo_q;
    end

endmodule

// File: rtl/gpio_defaults_array.sv
// Bank of per-pad GPIO default configuration words with runtime write/restore
// and serial load into the GPIO control chain. GPIO_DEFAULTS_LOCK_EN adds a sticky lock.
module gpio_defaults_array
    import gpio_defaults_pkg::*;
#(
    parameter int unsigned                  NUM_GPIO = 38,
    parameter int unsigned                  CFG_W    = 10,
    parameter logic [NUM_GPIO*CFG_W-1:0]    CFG_INIT = {NUM_GPIO{GPIO_DEFAULT_WORD}},
    parameter int unsigned                  CLK_DIV  = 2
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rstn_i,
    input  logic                            wr_en,
    input  logic [idx_width(NUM_GPIO)-1:0]  wr_idx,
    input  logic [CFG_W-1:0]                wr_data,
    output logic                            wr_err,
    input  logic                            restore,
    input  logic                            xfer_start,
    output logic                            busy,
    output logic                            serial_clock,
    output logic                            serial_load,
    output logic                            serial_data_out,
`ifdef GPIO_DEFAULTS_LOCK_EN
    input  logic                            lock_set,
    output logic                            locked,
`endif
    output logic [NUM_GPIO*CFG_W-1:0]       gpio_cfg
);

    localparam int unsigned TOTAL = NUM_GPIO * CFG_W;

    logic [TOTAL-1:0] cfg_q, cfg_d;
    logic             err_q, err_d;
    logic             pend_q, pend_d;
    logic             ser_start;
    logic             ser_busy;
    logic             lock_active;
    logic             idx_ok;
    logic             blocked;
    logic             do_restore;
    logic             do_write;
    logic             start_req;

`ifdef GPIO_DEFAULTS_LOCK_EN
    logic locked_q, locked_d;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            locked_q <= 1'b0;
        end else begin
            locked_q <= locked_d;
        end
    end

    always_comb begin
        locked_d    = locked_q | lock_set;
        lock_active = locked_q;
        locked      = locked_q;
    end
`else
    always_comb lock_active = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            cfg_q  <= CFG_INIT;
            err_q  <= 1'b0;
            pend_q <= 1'b1;
        end else begin
            cfg_q  <= cfg_d;
            err_q  <= err_d;
            pend_q <= pend_d;
        end
    end

    // A start coinciding with an accepted update is held one cycle in pend_q
    // so the serializer only ever sees the updated words.
    always_comb begin
        idx_ok     = (32'(wr_idx) < NUM_GPIO);
        blocked    = ser_busy || lock_active;
        do_restore = restore && !blocked;
        do_write   = wr_en && !restore && !blocked && idx_ok;
        err_d      = (restore && blocked) || (wr_en && !restore && (blocked || !idx_ok));

        cfg_d = cfg_q;
        if (do_restore) begin
            cfg_d = CFG_INIT;
        end else if (do_write) begin
            for (int unsigned i = 0; i < NUM_GPIO; i++) begin
                if (32'(wr_idx) == i) begin
                    cfg_d[i*CFG_W +: CFG_W] = wr_data;
                end
            end
        end

        start_req = xfer_start || pend_q;
        ser_start = start_req && !ser_busy && !(do_restore || do_write);
        pend_d    = start_req && !ser_busy && (do_restore || do_write);
    end

    gpio_defaults_serializer #(
        .TOTAL_BITS (TOTAL),
        .CLK_DIV    (CLK_DIV)
    ) u_serializer (
        .clk             (wb_clk_i),
        .rst_n           (wb_rstn_i),
        .start           (ser_start),
        .words           (cfg_q),
        .busy            (ser_busy),
        .serial_clock    (serial_clock),
        .serial_load     (serial_load),
        .serial_data_out (serial_data_out)
    );

    always_comb begin
        busy     = ser_busy;
        wr_err   = err_q;
        gpio_cfg = cfg_q;
    end

endmodule

// File: doc/gpio_defaults_array.md
# gpio_defaults_array

Parametrised bank of per-pad GPIO default configuration words for the whole pad ring. Each channel holds a `CFG_W`-bit word that resets to a mask-programmed value. Management can overwrite a word at runtime or restore all defaults. The bank serially shifts every word into the chained GPIO control blocks, automatically after reset and again on request. It sits between housekeeping and the GPIO control block chain and replaces the fixed single-pad defaults cells.

## Interface
- `NUM_GPIO`, 38, number of pad channels (≥1).
- `CFG_W`, 10, bits per configuration word (≥1).
- `CFG_INIT`, `{NUM_GPIO{10'h007}}`, packed `NUM_GPIO*CFG_W` reset words; channel i occupies bits `[i*CFG_W +: CFG_W]`.
- `CLK_DIV`, 2, `wb_clk_i` cycles per serial_clock half-period (≥1).

Ports:
- `wb_clk_i`  in  1  clock; all logic rising-edge.
- `wb_rstn_i`  in  1  reset, synchronous, active-low.
- `wr_en`  in  1  write strobe.
- `wr_idx`  in  `$clog2(NUM_GPIO)` (min 1)  channel index.
- `wr_data`  in  `CFG_W`  new word.
- `wr_err`  out  1  one-cycle pulse, write or restore rejected.
- `restore`  in  1  reload all words from `CFG_INIT`.
- `xfer_start`  in  1  request serial transfer.
- `busy`  out  1  transfer in progress.
- `serial_clock`  out  1  chain shift clock.
- `serial_load`  out  1  chain latch pulse.
- `serial_data_out`  out  1  chain data.
- `gpio_cfg`  out  `NUM_GPIO*CFG_W`  current words, same packing as `CFG_INIT`.
- `lock_set`, `locked`: see Configuration.

## Operation
- Reset: words = `CFG_INIT`; state IDLE; `busy`, `serial_*`, `wr_err` all 0.
- An automatic transfer is pending out of reset and starts on the first cycle `wb_rstn_i` is high, exactly as if `xfer_start` had been sampled.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LOAD.
  - IDLE→SHIFT_LO on start.
  - SHIFT_LO→SHIFT_HI after `CLK_DIV` cycles.
  - SHIFT_HI→SHIFT_LO after `CLK_DIV` cycles if bits remain, else →LOAD.
  - LOAD→IDLE after `CLK_DIV` cycles.
- Bit order: channel `NUM_GPIO-1` first, down to channel 0. Each word goes MSB first. Total `NUM_GPIO*CFG_W` bits, counted by a down-counter.
- `serial_data_out` changes only on entry to SHIFT_LO. It is 0 in IDLE and LOAD.
- `serial_clock` is 1 only in SHIFT_HI. `serial_load` is 1 only in LOAD.
- Writes: an accepted `wr_en` updates `gpio_cfg` next cycle.
  - A write is rejected (`wr_err` pulse next cycle, no update) if `busy`, or if `wr_idx ≥ NUM_GPIO`.
- `restore`: reloads all words next cycle. It is rejected with `wr_err` if `busy`.
- Simultaneous `restore` and `wr_en`: restore wins, and the write is dropped without `wr_err`.
- Simultaneous `restore`/`wr_en` and `xfer_start` in IDLE: the update applies, then the transfer starts the following cycle and shifts the updated words.
- `xfer_start` while busy is ignored and not queued.
- Reset mid-transfer: outputs return to reset values next cycle, the partial shift is abandoned, and the auto transfer restarts.

## Timing
- `xfer_start` sampled at cycle 0 → `busy`=1 and first bit on `serial_data_out` from cycle 1.
- First `serial_clock` rise at cycle `1+CLK_DIV`.
- Each bit takes `2*CLK_DIV` cycles.
- `serial_load` is high for `CLK_DIV` cycles immediately after the last SHIFT_HI.
- `busy` falls on the cycle after LOAD ends.
- Total busy = `(2*NUM_GPIO*CFG_W+1)*CLK_DIV` cycles.
- Write latency: 1 cycle to `gpio_cfg`. `gpio_cfg` is registered.

## Configuration
- `GPIO_DEFAULTS_LOCK_EN` defined:
  - Adds ports `lock_set` in 1 and `locked` out 1.
  - `lock_set` sets sticky `locked` next cycle. `locked` resets to 0 and is cleared only by reset.
  - While `locked`, `wr_en` and `restore` are rejected with `wr_err`.
  - `xfer_start` is still honoured.
- Not defined: the ports are absent and there is no lock behaviour.

## Structure
- Package `gpio_defaults_pkg`: state enum (IDLE, SHIFT_LO, SHIFT_HI, LOAD) and the default word constant `10'h007`.
- Sub-module `gpio_defaults_serializer`: FSM, divider and bit counters. It takes the packed word vector and start, and produces `busy` and `serial_*`.
- Top level: word registers, write/restore/lock arbitration and `wr_err`.

## Test plan
- Reset release, `NUM_GPIO`=2, `CFG_W`=10, `CLK_DIV`=1, `CFG_INIT`={10'h201,10'h007}:
  - Auto transfer shifts `1000000001_0000000111` in that order.
  - 20 serial_clock pulses, then `serial_load` high 1 cycle.
  - `busy` high for 41 cycles.
- Write ch0=10'h3FF in IDLE → `gpio_cfg[9:0]`=10'h3FF next cycle. `xfer_start` then shifts `...1111111111` as its last 10 bits.
- `wr_en` with `wr_idx`=2 (`NUM_GPIO`=2), and separately `wr_en` during `busy` → `wr_err` pulse, `gpio_cfg` unchanged.
- `restore`+`xfer_start` same cycle after modifications → words equal `CFG_INIT`. The transfer starts one cycle later and shifts the defaults.
- Reset asserted at bit 7 of a transfer → next cycle all `serial_*`=0 and `busy`=0. After release, a full transfer restarts from bit 0.
- `GPIO_DEFAULTS_LOCK_EN`: `lock_set` → `locked`=1. A write to ch1 gives `wr_err`, ch1 unchanged. `xfer_start` still completes.
